// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
//   mux_state_t : arbitration FSM state (idle / locked to one channel)
//   rr_next     : successor of a channel index with wrap from n-1 to 0
package stream_mux_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } mux_state_t;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter.
//   req       : request vector, one bit per channel
//   ptr       : round-robin start index (ignored when FIXED_PRIO = 1)
//   grant     : one-hot grant, zero when nothing requests
//   grant_idx : binary index of the granted channel
//   any_grant : at least one request was granted
module rr_arbiter #(
    parameter int N          = 4,
    parameter int FIXED_PRIO = 0,
    parameter int SELW       = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx,
    output logic            any_grant
);

    int idx;

    // Walk the channels starting at ptr (or 0 for fixed priority); the
    // first requester found wins. Non-power-of-two N wraps explicitly.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            if (FIXED_PRIO != 0) begin
                idx = k;
            end else begin
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
            end
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = SELW'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with registered output and packet-aware
// arbitration. Multi-beat packets hold the grant until their LAST beat.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : N packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel beat valid
//   in_last    : per-channel end-of-packet, qualified by in_valid
//   in_ready   : per-channel accept, one-hot or zero
//   out_data   : registered data of the held beat
//   out_valid  : output beat valid
//   out_last   : registered LAST of the held beat
//   out_sel    : channel that supplied the held beat
//   out_ready  : downstream accept
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | no packet in flight; arbiter picks among valid channels
// ST_LOCKED | mid-packet; grant pinned to lock_ch until its LAST beat
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int N          = 4,
    parameter int FIXED_PRIO = 0,
    parameter int SELW       = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    mux_state_t       state, state_nxt;
    logic [SELW-1:0]  lock_ch, lock_ch_nxt;
    logic [SELW-1:0]  ptr, ptr_nxt;

    logic [N-1:0]     arb_grant;
    logic [SELW-1:0]  arb_idx;
    logic             arb_any;

    logic             load_ok;
    logic             grant_vld;
    logic [SELW-1:0]  grant_ch;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    rr_arbiter #(
        .N          (N),
        .FIXED_PRIO (FIXED_PRIO),
        .SELW       (SELW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    assign load_ok = !out_valid || out_ready;

    // Grant source depends only on state, so a locked channel dropping
    // valid leaves a bubble rather than letting another channel in.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        in_ready  = '0;
        case (state)
            ST_IDLE: begin
                grant_vld = arb_any;
                grant_ch  = arb_idx;
                if (load_ok && rst_n) begin
                    in_ready = arb_grant;
                end
            end
            ST_LOCKED: begin
                grant_vld = 1'b1;
                grant_ch  = lock_ch;
                for (int i = 0; i < N; i++) begin
                    if (lock_ch == SELW'(i)) begin
                        in_ready[i] = load_ok && rst_n;
                    end
                end
            end
            default: begin
                grant_vld = 1'b0;
            end
        endcase
    end

    assign accept = |(in_valid & in_ready);

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_ch == SELW'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
                sel_last = in_last[i];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        lock_ch_nxt = lock_ch;
        ptr_nxt     = ptr;
        if (accept && grant_vld) begin
            if (sel_last) begin
                state_nxt = ST_IDLE;
                ptr_nxt   = SELW'(rr_next(int'(grant_ch), N));
            end else begin
                state_nxt   = ST_LOCKED;
                lock_ch_nxt = grant_ch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lock_ch <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_ch_nxt;
            ptr     <= ptr_nxt;
        end
    end

    // Loading on accept also covers the case where the held beat leaves
    // in the same cycle, which is what keeps throughput at one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (accept) begin
            out_data  <= sel_data;
            out_valid <= 1'b1;
            out_last  <= sel_last;
            out_sel   <= grant_ch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst_n;
    logic out_ready;

    always #5 clk = ~clk;

    // N=4 round robin
    logic [127:0] a_data;
    logic [3:0]   a_valid, a_last, a_ready;
    logic [31:0]  a_odata;
    logic         a_ovalid, a_olast;
    logic [1:0]   a_osel;

    // N=4 fixed priority
    logic [127:0] f_data;
    logic [3:0]   f_valid, f_last, f_ready;
    logic [31:0]  f_odata;
    logic         f_ovalid, f_olast;
    logic [1:0]   f_osel;

    // N=3 round robin
    logic [95:0]  c_data;
    logic [2:0]   c_valid, c_last, c_ready;
    logic [31:0]  c_odata;
    logic         c_ovalid, c_olast;
    logic [1:0]   c_osel;

    int vectors = 0;
    int miscompares = 0;

    stream_mux_rr #(.WIDTH(32), .N(4), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_last(a_last), .in_ready(a_ready), .out_data(a_odata),
        .out_valid(a_ovalid), .out_last(a_olast), .out_sel(a_osel),
        .out_ready(out_ready));

    stream_mux_rr #(.WIDTH(32), .N(4), .FIXED_PRIO(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .in_data(f_data), .in_valid(f_valid),
        .in_last(f_last), .in_ready(f_ready), .out_data(f_odata),
        .out_valid(f_ovalid), .out_last(f_olast), .out_sel(f_osel),
        .out_ready(out_ready));

    stream_mux_rr #(.WIDTH(32), .N(3), .FIXED_PRIO(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid),
        .in_last(c_last), .in_ready(c_ready), .out_data(c_odata),
        .out_valid(c_ovalid), .out_last(c_olast), .out_sel(c_osel),
        .out_ready(out_ready));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_data = '0; a_valid = '0; a_last = '0;
        f_data = '0; f_valid = '0; f_last = '0;
        c_data = '0; c_valid = '0; c_last = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        clear_inputs();
        a_valid = 4'hF; a_last = 4'hF;
        step();
        vectors++;
        if (a_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 0000", a_ready);
        end
        vectors++;
        if (a_ovalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 0", a_ovalid);
        end
        vectors++;
        if (a_odata !== 32'h0 || a_olast !== 1'b0 || a_osel !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_out_regs: data %h last %b sel %0d want 0/0/0",
                     a_odata, a_olast, a_osel);
        end
        do_reset();
    endtask

    task automatic test_single_beat();
        do_reset();
        a_valid = 4'b0100;
        a_last  = 4'b0100;
        a_data[2*32 +: 32] = 32'hFBFBADAD;
        #1;
        vectors++;
        if (a_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_in_ready: got %b want 0100", a_ready);
        end
        step();
        a_valid = '0;
        vectors++;
        if (a_ovalid !== 1'b1 || a_odata !== 32'hFBFBADAD) begin
            miscompares++;
            $display("FAIL single_data: valid %b data %h want 1 FBFBADAD", a_ovalid, a_odata);
        end
        vectors++;
        if (a_osel !== 2'd2 || a_olast !== 1'b1) begin
            miscompares++;
            $display("FAIL single_sel_last: sel %0d last %b want 2 1", a_osel, a_olast);
        end
        step();
        vectors++;
        if (a_ovalid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drain: valid %b want 0", a_ovalid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        a_valid = 4'hF;
        a_last  = 4'hF;
        for (int i = 0; i < 4; i++) a_data[i*32 +: 32] = 32'hA000_0000 + i;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if (a_ovalid !== 1'b1 || a_osel !== 2'(k % 4) ||
                a_odata !== 32'hA000_0000 + (k % 4)) begin
                miscompares++;
                $display("FAIL rr_seq[%0d]: valid %b sel %0d data %h want 1 %0d %h",
                         k, a_ovalid, a_osel, a_odata, k % 4, 32'hA000_0000 + (k % 4));
            end
        end
        a_valid = '0;
    endtask

    task automatic test_fixed_prio();
        do_reset();
        f_valid = 4'hF;
        f_last  = 4'hF;
        for (int i = 0; i < 4; i++) f_data[i*32 +: 32] = 32'hF000_0000 + i;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if (f_ovalid !== 1'b1 || f_osel !== 2'd0 || f_odata !== 32'hF000_0000) begin
                miscompares++;
                $display("FAIL fixed_seq[%0d]: valid %b sel %0d data %h want 1 0 F0000000",
                         k, f_ovalid, f_osel, f_odata);
            end
        end
        f_valid = 4'b1110;
        step();
        vectors++;
        if (f_osel !== 2'd1 || f_odata !== 32'hF000_0001) begin
            miscompares++;
            $display("FAIL fixed_lowest: sel %0d data %h want 1 F0000001", f_osel, f_odata);
        end
        f_valid = '0;
    endtask

    task automatic test_non_pow2();
        do_reset();
        c_valid = 3'b111;
        c_last  = 3'b111;
        for (int i = 0; i < 3; i++) c_data[i*32 +: 32] = 32'hC000_0000 + i;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if (c_ovalid !== 1'b1 || c_osel !== 2'(k % 3) ||
                c_odata !== 32'hC000_0000 + (k % 3)) begin
                miscompares++;
                $display("FAIL n3_seq[%0d]: valid %b sel %0d data %h want 1 %0d",
                         k, c_ovalid, c_osel, c_odata, k % 3);
            end
        end
        c_valid = '0;
    endtask

    task automatic test_packet_lock();
        do_reset();
        a_valid = 4'b0011;
        a_last  = 4'b0001;
        a_data[0 +: 32]  = 32'h0000_0C00;
        a_data[32 +: 32] = 32'h1111_0001;
        #1;
        vectors++;
        if (a_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL lock_first_grant: got %b want 0001", a_ready);
        end
        step();
        vectors++;
        if (a_osel !== 2'd0 || a_odata !== 32'h0000_0C00) begin
            miscompares++;
            $display("FAIL lock_prime: sel %0d data %h want 0 00000C00", a_osel, a_odata);
        end
        step();
        vectors++;
        if (a_osel !== 2'd1 || a_odata !== 32'h1111_0001 || a_olast !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_beat1: sel %0d data %h last %b want 1 11110001 0",
                     a_osel, a_odata, a_olast);
        end
        // Locked channel drops valid: bubble, ch0 must not get in.
        a_data[32 +: 32] = 32'h1111_0002;
        a_valid = 4'b0001;
        #1;
        vectors++;
        if (a_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL lock_bubble_ready: got %b want 0010", a_ready);
        end
        step();
        vectors++;
        if (a_ovalid !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_bubble_valid: got %b want 0", a_ovalid);
        end
        a_valid = 4'b0011;
        step();
        vectors++;
        if (a_osel !== 2'd1 || a_odata !== 32'h1111_0002) begin
            miscompares++;
            $display("FAIL lock_beat2: sel %0d data %h want 1 11110002", a_osel, a_odata);
        end
        a_data[32 +: 32] = 32'h1111_0003;
        a_last = 4'b0011;
        step();
        vectors++;
        if (a_osel !== 2'd1 || a_odata !== 32'h1111_0003 || a_olast !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_beat3: sel %0d data %h last %b want 1 11110003 1",
                     a_osel, a_odata, a_olast);
        end
        a_valid = 4'b0001;
        step();
        vectors++;
        if (a_osel !== 2'd0 || a_odata !== 32'h0000_0C00 || a_ovalid !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_release: sel %0d data %h valid %b want 0 00000C00 1",
                     a_osel, a_odata, a_ovalid);
        end
        a_valid = '0;
    endtask

    task automatic test_back_pressure();
        do_reset();
        out_ready = 1'b0;
        a_valid = 4'b1000;
        a_last  = 4'b1000;
        a_data[3*32 +: 32] = 32'h3000_0000;
        #1;
        vectors++;
        if (a_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL bp_first_ready: got %b want 1000", a_ready);
        end
        step();
        a_data[3*32 +: 32] = 32'h3000_0001;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (a_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL bp_stall_ready[%0d]: got %b want 0000", k, a_ready);
            end
            step();
            vectors++;
            if (a_ovalid !== 1'b1 || a_odata !== 32'h3000_0000) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: valid %b data %h want 1 30000000",
                         k, a_ovalid, a_odata);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (a_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL bp_resume_ready: got %b want 1000", a_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            vectors++;
            if (a_ovalid !== 1'b1 || a_odata !== 32'h3000_0000 + k) begin
                miscompares++;
                $display("FAIL bp_stream[%0d]: valid %b data %h want 1 %h",
                         k, a_ovalid, a_odata, 32'h3000_0000 + k);
            end
            a_data[3*32 +: 32] = 32'h3000_0000 + k + 1;
        end
        a_valid = '0;
        step();
        vectors++;
        if (a_ovalid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: valid %b want 0", a_ovalid);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        a_valid = 4'b0010;
        a_last  = 4'b0000;
        a_data[32 +: 32] = 32'h2000_0001;
        step();
        a_valid = 4'b0011;
        a_data[0 +: 32]  = 32'h0000_00AA;
        a_data[32 +: 32] = 32'h2000_0002;
        step();
        vectors++;
        if (a_osel !== 2'd1 || a_odata !== 32'h2000_0002) begin
            miscompares++;
            $display("FAIL rstmid_beat2: sel %0d data %h want 1 20000002", a_osel, a_odata);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (a_ovalid !== 1'b0 || a_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstmid_clear: valid %b ready %b want 0 0000", a_ovalid, a_ready);
        end
        step();
        rst_n = 1'b1;
        a_last = 4'b0011;
        #1;
        vectors++;
        if (a_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL rstmid_regrant: ready %b want 0001", a_ready);
        end
        step();
        vectors++;
        if (a_osel !== 2'd0 || a_odata !== 32'h0000_00AA || a_ovalid !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_after: sel %0d data %h valid %b want 0 000000AA 1",
                     a_osel, a_odata, a_ovalid);
        end
        a_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_round_robin();
        test_fixed_prio();
        test_non_pow2();
        test_packet_lock();
        test_back_pressure();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-to-1 stream multiplexer with a registered output, valid/ready handshakes and packet-aware round-robin arbitration. It is the next generation of the datapath 2-to-1 select mux. It generalises data width and channel count, and replaces the external select with an internal arbiter. Inside the RV32I datapath it merges requesters (fetch, load/store, debug) onto one shared memory/bus port without splitting multi-beat transfers.

## Interface
- `WIDTH`, 32, data width in bits per channel.
- `N`, 4, number of input channels, N ≥ 2 (need not be a power of two).
- `FIXED_PRIO`, 0: round-robin; 1: fixed priority, lowest index wins.
- `SELW`, $clog2(N), derived width of the channel index.
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `IN_DATA`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `IN_VALID`  in  N  per-channel beat valid.
- `IN_LAST`  in  N  per-channel end-of-packet marker, qualified by `IN_VALID`.
- `IN_READY`  out  N  per-channel accept; at most one bit set (one-hot or zero).
- `OUT_DATA`  out  WIDTH  registered selected data.
- `OUT_VALID`  out  1  output beat valid.
- `OUT_LAST`  out  1  registered `IN_LAST` of the held beat.
- `OUT_SEL`  out  SELW  index of the channel that supplied the held beat.
- `OUT_READY`  in  1  downstream accept.

## Operation
- **Output stage.**
  - One register stage holds {DATA, LAST, SEL}.
  - Stage can load when `load_ok = !OUT_VALID || OUT_READY`.
- **Handshake.**
  - Input beat i transfers when `IN_VALID[i] && IN_READY[i]`.
  - Output beat transfers when `OUT_VALID && OUT_READY`.
  - `IN_READY[i]` = `load_ok` && grant==i, where grant comes from the current state.
- **FSM states.**
  - IDLE: grant = arbiter pick among asserted `IN_VALID`; zero requests means no grant.
  - LOCKED(ch): grant = ch regardless of other requests. `IN_VALID[ch]` low leaves the bubble in place with no re-arbitration.
- **Transitions.**
  - IDLE→LOCKED(g) on an accepted beat from g with `IN_LAST`=0.
  - LOCKED→IDLE on an accepted beat with `IN_LAST`=1.
  - An accepted single beat with LAST=1 in IDLE stays in IDLE.
- **Round-robin pointer.**
  - Search starts at ptr, ptr+1, … and wraps from N-1 to 0.
  - On an accepted LAST beat from channel g, ptr ← (g==N-1) ? 0 : g+1.
  - `FIXED_PRIO`=1 ignores ptr; the lowest asserted index wins.
- **Data is never altered.** `OUT_DATA` equals the accepted `IN_DATA` slice bit-exactly.
- **Simultaneous events.**
  - Downstream accept and a new input accept in the same cycle: the register is replaced, giving full throughput.
  - `IN_VALID` may drop on an unselected channel at any time with no effect.

## Timing
- Latency is 1 cycle: a beat accepted at edge k appears on `OUT_*` after edge k.
- Throughput is 1 beat/cycle with `OUT_READY` held high.
- A locked packet is never interleaved with another channel's beats.
- `IN_READY` is combinational from state, `IN_VALID` and `OUT_READY`. There is no combinational path from `IN_DATA` to any output.
- **Reset values (async assert, sync-released use assumed by integration).**
  - `OUT_VALID`=0, `OUT_DATA`=0, `OUT_LAST`=0, `OUT_SEL`=0.
  - ptr=0, state=IDLE.
  - `IN_READY`=0 while `RST_N` is low.
- **Reset mid-packet.** The lock is dropped and the held beat is discarded (`OUT_VALID`=0). After release, arbitration restarts from channel 0.

## Structure
- Package `stream_mux_pkg` holds:
  - state typedef `mux_state_t` {ST_IDLE, ST_LOCKED};
  - a helper function `rr_next(ptr, N)` for wrap-around.
- Sub-module `rr_arbiter` (N, FIXED_PRIO) is purely combinational:
  - inputs: request vector, ptr;
  - outputs: one-hot grant, binary index, any-grant.
- The top level holds the FSM, ptr, lock channel and output register.

## Test plan
- Reset, then N=4 with only ch2 valid, DATA=32'hFBFBADAD, LAST=1, `OUT_READY`=1 → `IN_READY`=4'b0100. Next cycle `OUT_DATA`=FBFBADAD, `OUT_SEL`=2, `OUT_LAST`=1.
- All four channels valid with single-beat packets (LAST=1), `OUT_READY`=1 → `OUT_SEL` sequence 0,1,2,3,0 on consecutive cycles. With `FIXED_PRIO`=1 → 0,0,0,….
- ch1 sends a 3-beat packet (LAST on beat 3) while ch0 stays valid → `OUT_SEL`=1,1,1 uninterrupted, then 0 is granted.
- `OUT_READY`=0 for 3 cycles with ch3 valid → `OUT_DATA` is held stable and `IN_READY`=0 after the first load. Raising `OUT_READY` resumes at 1 beat/cycle with no loss or duplication.
- `RST_N` pulsed low during beat 2 of a 4-beat ch1 packet → `OUT_VALID`=0 immediately. After release, ch0 and ch1 both valid gives grant 0.
- N=3 with all channels valid (non-power-of-two wrap) → `OUT_SEL` sequence 0,1,2,0,1.
